// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, computes the result at issue and
// holds it back for a fixed busy period so the pipeline sees realistic MD latency.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall
);

    localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW    = $clog2(MAX_N + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic          pend_ok_q, pend_ok_d;

    logic [63:0]   prod;
    logic          div_signed;
    logic [31:0]   dvd_mag;
    logic [31:0]   dvs_raw;
    logic [31:0]   dvs_mag;
    logic [31:0]   quo_mag;
    logic [31:0]   rem_mag;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          is_md_op;

    assign is_md_op = (mdop <= OP_DIVU);

    // Sign-extending both operands to 64 bits makes the low 64 bits of the product
    // the correct two's-complement result for the signed case.
    always_comb begin
        prod = 64'd0;
        if (mdop == OP_MULT) begin
            prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        end else begin
            prod = {32'd0, a} * {32'd0, b};
        end
    end

    // Signed division on magnitudes: quotient truncates toward zero, remainder
    // follows the dividend; 0x80000000 / -1 wraps back to 0x80000000.
    always_comb begin
        div_signed = (mdop == OP_DIV);
        dvd_mag    = (div_signed && a[31]) ? (~a + 32'd1) : a;
        dvs_raw    = (div_signed && b[31]) ? (~b + 32'd1) : b;
        dvs_mag    = (b == 32'd0) ? 32'd1 : dvs_raw;
        quo_mag    = dvd_mag / dvs_mag;
        rem_mag    = dvd_mag % dvs_mag;
    end

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        if (mdop[1]) begin
            res_lo = (div_signed && (a[31] ^ b[31])) ? (~quo_mag + 32'd1) : quo_mag;
            res_hi = (div_signed && a[31]) ? (~rem_mag + 32'd1) : rem_mag;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (mdop)
                        OP_MULT, OP_MULTU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            pend_ok_d = 1'b1;
                            cnt_d     = CW'(MULT_CYCLES);
                            state_d   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            // A zero divisor still burns the full latency but never commits.
                            pend_ok_d = (b != 32'd0);
                            cnt_d     = CW'(DIV_CYCLES);
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (pend_ok_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign hi    = hi_q;
    assign lo    = lo_q;
    // Holds an MD-class D instruction while busy, and already in the issue cycle.
    assign stall = md_use & (busy | (start & is_md_op));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed plus random checks of mdu_ctrl against a completion-time reference model.
module tb_mdu_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;

  int total = 0;
  int bad   = 0;

  // reference model: result is known at issue, applied at the edge numbered m_done
  int          edge_n = 0;
  int          m_done = 0;
  logic        m_busy = 1'b0;
  logic        m_ok   = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] p_hi   = '0;
  logic [31:0] p_lo   = '0;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop), .a(a), .b(b),
    .md_use(md_use), .busy(busy), .hi(hi), .lo(lo), .stall(stall)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_result(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb,
                            output logic [31:0] rh, output logic [31:0] rl);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     r64, q64;
    sa = $signed(aa);
    sb = $signed(bb);
    ua = aa;
    ub = bb;
    rh = m_hi;
    rl = m_lo;
    case (op)
      3'd0: begin r64 = sa * sb; rh = r64[63:32]; rl = r64[31:0]; end
      3'd1: begin r64 = ua * ub; rh = r64[63:32]; rl = r64[31:0]; end
      3'd2: if (bb != 0) begin q64 = sa / sb; r64 = sa % sb; rl = q64[31:0]; rh = r64[31:0]; end
      3'd3: if (bb != 0) begin q64 = ua / ub; r64 = ua % ub; rl = q64[31:0]; rh = r64[31:0]; end
      default: ;
    endcase
  endtask

  task automatic model_edge(input logic st, input logic [2:0] op,
                            input logic [31:0] aa, input logic [31:0] bb);
    edge_n++;
    if (m_busy) begin
      if (edge_n == m_done) begin
        m_busy = 1'b0;
        if (m_ok) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end
    end else if (st) begin
      if (op <= 3'd3) begin
        ref_result(op, aa, bb, p_hi, p_lo);
        m_ok   = !(op >= 3'd2 && bb == 0);
        m_done = edge_n + ((op >= 3'd2) ? DIV_N : MULT_N);
        m_busy = 1'b1;
      end else if (op == 3'd4) begin
        m_hi = aa;
      end else if (op == 3'd5) begin
        m_lo = aa;
      end
    end
  endtask

  // driver: one full clock cycle with the given E/D-stage inputs
  task automatic cycle(input logic st, input logic [2:0] op, input logic [31:0] aa,
                       input logic [31:0] bb, input logic mu);
    @(negedge clk);
    start  = st;
    mdop   = op;
    a      = aa;
    b      = bb;
    md_use = mu;
    #1;
    check("stall", {31'd0, stall}, {31'd0, mu & (m_busy | (st & (op <= 3'd3)))});
    @(posedge clk);
    model_edge(st, op, aa, bb);
    #1;
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask

  task automatic idle(input int n, input logic mu);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd7, 32'd0, 32'd0, mu);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    mdop   = 3'd7;
    a      = '0;
    b      = '0;
    md_use = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // mult -2 * 3
    cycle(1'b1, 3'd0, 32'hFFFFFFFE, 32'd3, 1'b1);
    idle(6, 1'b1);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    // multu max * max
    cycle(1'b1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    idle(6, 1'b0);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    // div -7 / 2, then divide by zero
    cycle(1'b1, 3'd2, 32'hFFFFFFF9, 32'd2, 1'b1);
    idle(11, 1'b1);
    check("div_hi", hi, 32'hFFFFFFFF);
    check("div_lo", lo, 32'hFFFFFFFD);
    cycle(1'b1, 3'd3, 32'd7, 32'd0, 1'b0);
    idle(11, 1'b0);
    check("div0_hi", hi, 32'hFFFFFFFF);
    check("div0_lo", lo, 32'hFFFFFFFD);

    // overflow divide
    cycle(1'b1, 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    idle(11, 1'b0);
    check("ovf_hi", hi, 32'd0);
    check("ovf_lo", lo, 32'h80000000);

    // mthi / mtlo back to back
    cycle(1'b1, 3'd4, 32'h12345678, 32'd0, 1'b0);
    check("mthi_hi", hi, 32'h12345678);
    cycle(1'b1, 3'd5, 32'h9ABCDEF0, 32'd0, 1'b0);
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    idle(2, 1'b0);

    // mthi while a mult is running is ignored
    cycle(1'b1, 3'd0, 32'd3, 32'd4, 1'b1);
    cycle(1'b1, 3'd4, 32'hDEADBEEF, 32'd0, 1'b1);
    idle(5, 1'b1);
    check("mult34_hi", hi, 32'd0);
    check("mult34_lo", lo, 32'd12);

    // a new start landing on the completion edge is ignored
    cycle(1'b1, 3'd1, 32'd6, 32'd7, 1'b0);
    idle(4, 1'b0);
    cycle(1'b1, 3'd1, 32'd100, 32'd100, 1'b1);
    check("late_busy", {31'd0, busy}, 32'd0);
    check("late_lo", lo, 32'd42);
    idle(2, 1'b1);

    // no-op opcodes
    cycle(1'b1, 3'd6, 32'h55555555, 32'd1, 1'b1);
    cycle(1'b1, 3'd7, 32'h55555555, 32'd1, 1'b1);

    // asynchronous reset in the third cycle of a div
    cycle(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    idle(2, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    m_busy = 1'b0;
    m_hi   = '0;
    m_lo   = '0;
    @(negedge clk);
    reset = 1'b0;
    idle(12, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), pick_val(), pick_val(),
            1'($urandom_range(0, 1)));
    end
    idle(12, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
